enc_sample_sched: RTL and testbench

Sequences the quadrature position counter for the control loop: homes on the encoder index pulse, then samples the signed position at a programmable period. Each sample yields a wrap-corrected velocity (delta counts per period). Results go to the downstream loop controller over a valid/ready handshake, with overspeed and homing-timeout fault detection. Sits between the ABZ decoder output and the servo/velocity loop in the encoder path.

---
 rtl/enc_sample_sched.sv | 214 +++++++++++++++++++++
 tb/tb_enc_sample_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_sample_sched.sv
// Encoder sample scheduler: homes on the index pulse, then samples position every period and
// emits wrap-corrected velocity over a 1-deep valid/ready buffer, with overspeed/homing faults.
module enc_sample_sched #(
   parameter int unsigned WRAP_SPAN = 1048577,
   parameter int unsigned HOME_TO   = 100000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] pos_in,
   input  logic        z_pulse,
   input  logic [15:0] cfg_period,
   input  logic [19:0] cfg_vmax,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pos,
   output logic [31:0] out_vel,
   output logic        homed,
   output logic        busy,
   output logic        fault,
   output logic [1:0]  fault_code,
   output logic        overrun
);

   localparam int unsigned HW = (HOME_TO > 2) ? $clog2(HOME_TO) : 1;
   localparam logic [HW-1:0] HOME_LAST = HW'(HOME_TO - 1);
   localparam logic signed [32:0] SPAN = 33'(WRAP_SPAN);
   localparam logic signed [32:0] HALF = 33'(WRAP_SPAN / 2);

   typedef enum logic [1:0] {StIdle, StHoming, StRun, StFault} state_e;

   state_e             state_q, state_d;
   logic [HW-1:0]      hcnt_q, hcnt_d;
   logic [15:0]        pcnt_q, pcnt_d;
   logic [15:0]        per_q, per_d;
   logic [15:0]        per_cfg;
   logic               s_vld_q, s_vld_d;
   logic               d_vld_q, d_vld_d;
   logic [31:0]        s_pos_q, d_pos_q;
   logic [31:0]        pos_prev_q, pos_prev_d;
   logic signed [32:0] d_q;
   logic signed [32:0] d_corr;
   logic [32:0]        d_abs;
   logic               homed_q, homed_d;
   logic               busy_q, fault_q;
   logic [1:0]         fcode_q, fcode_d;
   logic               out_valid_q, out_valid_d;
   logic [31:0]        out_pos_q, out_pos_d;
   logic [31:0]        out_vel_q, out_vel_d;
   logic               overrun_q, overrun_d;
   logic               tick, overspeed, enter_run, flush, load;

   assign per_cfg = (cfg_period < 16'd2) ? 16'd2 : cfg_period;
   assign tick    = (state_q == StRun) && (pcnt_q == per_q - 16'd1);

   always_comb begin
      d_corr = d_q;
      if (d_q > HALF) begin
         d_corr = d_q - SPAN;
      end else if (d_q < -HALF) begin
         d_corr = d_q + SPAN;
      end
      d_abs = d_corr[32] ? 33'(-d_corr) : 33'(d_corr);
   end

   assign overspeed = d_vld_q && (d_abs > {13'd0, cfg_vmax});

   always_comb begin
      state_d    = state_q;
      hcnt_d     = hcnt_q;
      pcnt_d     = pcnt_q;
      per_d      = per_q;
      homed_d    = homed_q;
      fcode_d    = fcode_q;
      pos_prev_d = pos_prev_q;
      enter_run  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (homed_q) begin
                  state_d    = StRun;
                  pos_prev_d = pos_in;
                  enter_run  = 1'b1;
               end else begin
                  state_d = StHoming;
                  hcnt_d  = '0;
               end
            end
         end
         StHoming: begin
            if (z_pulse) begin
               homed_d    = 1'b1;
               pos_prev_d = '0;
               state_d    = StRun;
               enter_run  = 1'b1;
            end else if (hcnt_q == HOME_LAST) begin
               state_d = StFault;
               fcode_d = 2'b01;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         StRun: begin
            if (tick) begin
               pcnt_d = '0;
               per_d  = per_cfg;
            end else begin
               pcnt_d = pcnt_q + 16'd1;
            end
            if (overspeed) begin
               state_d = StFault;
               fcode_d = 2'b10;
            end
         end
         StFault: ;
         default: state_d = StIdle;
      endcase
      if (s_vld_q) begin
         pos_prev_d = s_pos_q;
      end
      if (enter_run) begin
         pcnt_d = '0;
         per_d  = per_cfg;
      end
      if (abort) begin
         state_d = StIdle;
         fcode_d = 2'b00;
         homed_d = homed_q;
      end
   end

   // A fault drops any sample still in flight so outputs hold while faulted.
   assign flush   = abort | overspeed;
   assign s_vld_d = tick & ~flush;
   assign d_vld_d = s_vld_q & ~flush;
   assign load    = d_vld_q & ~abort;

   always_comb begin
      out_valid_d = out_valid_q;
      out_pos_d   = out_pos_q;
      out_vel_d   = out_vel_q;
      overrun_d   = overrun_q;
      if (abort) begin
         out_valid_d = 1'b0;
         overrun_d   = 1'b0;
      end else if (load) begin
         if (out_valid_q && !out_ready) begin
            overrun_d = 1'b1;
         end
         out_valid_d = 1'b1;
         out_pos_d   = d_pos_q;
         out_vel_d   = d_corr[31:0];
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         hcnt_q      <= '0;
         pcnt_q      <= '0;
         per_q       <= 16'd2;
         s_vld_q     <= 1'b0;
         d_vld_q     <= 1'b0;
         s_pos_q     <= '0;
         d_pos_q     <= '0;
         pos_prev_q  <= '0;
         d_q         <= '0;
         homed_q     <= 1'b0;
         busy_q      <= 1'b0;
         fault_q     <= 1'b0;
         fcode_q     <= 2'b00;
         out_valid_q <= 1'b0;
         out_pos_q   <= '0;
         out_vel_q   <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         pcnt_q      <= pcnt_d;
         per_q       <= per_d;
         s_vld_q     <= s_vld_d;
         d_vld_q     <= d_vld_d;
         pos_prev_q  <= pos_prev_d;
         homed_q     <= homed_d;
         busy_q      <= (state_d == StHoming) || (state_d == StRun);
         fault_q     <= (state_d == StFault);
         fcode_q     <= fcode_d;
         out_valid_q <= out_valid_d;
         out_pos_q   <= out_pos_d;
         out_vel_q   <= out_vel_d;
         overrun_q   <= overrun_d;
         if (tick) begin
            s_pos_q <= pos_in;
         end
         if (s_vld_q) begin
            d_q     <= $signed({s_pos_q[31], s_pos_q}) - $signed({pos_prev_q[31], pos_prev_q});
            d_pos_q <= s_pos_q;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_pos    = out_pos_q;
   assign out_vel    = out_vel_q;
   assign homed      = homed_q;
   assign busy       = busy_q;
   assign fault      = fault_q;
   assign fault_code = fcode_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_enc_sample_sched.sv
// Bench for enc_sample_sched: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against an event-queue model of the scheduler.
module tb_enc_sample_sched;

   localparam int unsigned HT   = 1000;
   localparam longint      SPAN = 1048577;
   localparam int MI = 0, MH = 1, MR = 2, MF = 3;

   logic        clk, rst_n, start, abort, z_pulse, out_ready;
   logic        out_valid, homed, busy, fault, overrun;
   logic [31:0] pos_in, out_pos, out_vel;
   logic [15:0] cfg_period;
   logic [19:0] cfg_vmax;
   logic [1:0]  fault_code;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;
   int tcnt = 0;
   int pos_mode = 0;
   int ramp = 0;

   enc_sample_sched #(.WRAP_SPAN(1048577), .HOME_TO(HT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pos_in(pos_in),
      .z_pulse(z_pulse), .cfg_period(cfg_period), .cfg_vmax(cfg_vmax),
      .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos), .out_vel(out_vel),
      .homed(homed), .busy(busy), .fault(fault), .fault_code(fault_code), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: samples are queued at the tick with their delta and surface 2 edges later.
   typedef struct {longint due; longint pos; longint d;} samp_t;
   samp_t  pend[$];
   samp_t  e;
   int     m_mode = MI;
   longint cyc = 0, m_next = 0, m_home0 = 0, m_prev = 0, m_pos = 0, m_vel = 0;
   longint d, mag, pn;
   int     per;
   bit     m_homed = 0, m_valid = 0, m_ovr = 0;
   int     m_code = 0;

   always @(posedge clk) begin
      cyc++;
      pn  = longint'($signed(pos_in));
      per = (cfg_period < 16'd2) ? 2 : int'(cfg_period);
      if (!rst_n) begin
         m_mode = MI; pend.delete(); m_homed = 0; m_valid = 0; m_ovr = 0; m_code = 0;
         m_pos = 0; m_vel = 0; m_prev = 0;
      end else if (abort) begin
         m_mode = MI; pend.delete(); m_valid = 0; m_ovr = 0; m_code = 0;
      end else begin
         if (pend.size() > 0 && pend[0].due == cyc) begin
            e = pend.pop_front();
            d = e.d;
            if (d > SPAN / 2) d = d - SPAN;
            else if (d < -(SPAN / 2)) d = d + SPAN;
            if (m_valid && !out_ready) m_ovr = 1;
            m_valid = 1;
            m_pos   = e.pos;
            m_vel   = d;
            mag     = (d < 0) ? -d : d;
            if (mag > longint'(cfg_vmax)) begin
               m_mode = MF; m_code = 2; pend.delete();
            end
         end else if (m_valid && out_ready) begin
            m_valid = 0;
         end
         case (m_mode)
            MI: if (start) begin
               if (m_homed) begin
                  m_mode = MR; m_prev = pn; m_next = cyc + per;
               end else begin
                  m_mode = MH; m_home0 = cyc;
               end
            end
            MH: if (z_pulse) begin
               m_homed = 1; m_prev = 0; m_mode = MR; m_next = cyc + per;
            end else if (cyc - m_home0 == longint'(HT)) begin
               m_mode = MF; m_code = 1;
            end
            MR: if (cyc == m_next) begin
               pend.push_back('{cyc + 2, pn, pn - m_prev});
               m_prev = pn;
               m_next = cyc + per;
            end
            default: ;
         endcase
      end
   end

   always @(posedge clk) begin
      logic [31:0] mv;
      #1;
      if (chk_en) begin
         mv = m_vel[31:0];
         cmp("out_valid", longint'(out_valid), longint'(m_valid));
         cmp("out_pos", longint'($signed(out_pos)), m_pos);
         cmp("out_vel", longint'($signed(out_vel)), longint'($signed(mv)));
         cmp("homed", longint'(homed), longint'(m_homed));
         cmp("busy", longint'(busy), longint'(m_mode == MH || m_mode == MR));
         cmp("fault", longint'(fault), longint'(m_mode == MF));
         cmp("fault_code", longint'(fault_code), longint'(m_code));
         cmp("overrun", longint'(overrun), longint'(m_ovr));
      end
   end

   task automatic step();
      @(negedge clk);
      start   = 1'b0;
      abort   = 1'b0;
      z_pulse = 1'b0;
      tcnt++;
      if (pos_mode == 1) begin
         ramp++;
         pos_in = 32'(ramp / 10);
      end else if (pos_mode == 2) begin
         pos_in = pos_in + 32'd1;
      end
   endtask

   task automatic wait_sample(input int bound, output longint vel, output longint pos,
                              output longint t);
      bit found = 0;
      vel = 0; pos = 0; t = 0;
      for (int i = 0; i < bound && !found; i++) begin
         step();
         if (out_valid) begin
            found = 1;
            vel = longint'($signed(out_vel));
            pos = longint'($signed(out_pos));
            t   = longint'(tcnt);
         end
      end
      if (!found) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_sample: no out_valid within %0d cycles", bound);
      end
   endtask

   longint v1, v2, v3, p1, p2, p3, t1, t2, t3;
   int     k, pw;

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; z_pulse = 1'b0; out_ready = 1'b1;
      pos_in = '0; cfg_period = 16'd100; cfg_vmax = 20'd1000;
      repeat (3) step();
      rst_n = 1'b1;
      chk_en = 1;
      step();
      cmp("rst_out_valid", longint'(out_valid), 0);
      cmp("rst_homed", longint'(homed), 0);
      cmp("rst_busy", longint'(busy), 0);

      // Homing then a +1/10clk ramp at period 100
      step(); start = 1'b1;
      repeat (10) step();
      z_pulse = 1'b1; ramp = 0; pos_mode = 1;
      step(); step();
      cmp("home_homed", longint'(homed), 1);
      cmp("home_busy", longint'(busy), 1);
      wait_sample(300, v1, p1, t1);
      wait_sample(200, v2, p2, t2);
      wait_sample(200, v3, p3, t3);
      cmp("ramp_vel2", v2, 10);
      cmp("ramp_vel3", v3, 10);
      cmp("ramp_period", t3 - t2, 100);

      // Wrap across the decoder modulus
      pos_mode = 0; pos_in = 32'd1048570;
      wait_sample(200, v1, p1, t1);
      wait_sample(200, v1, p1, t1);
      pos_in = 32'd5;
      wait_sample(200, v1, p1, t1);
      cmp("wrap_vel", v1, 12);
      cmp("wrap_pos", p1, 5);

      // Overspeed
      cfg_vmax = 20'd50;
      wait_sample(200, v1, p1, t1);
      pos_in = 32'd65;
      wait_sample(200, v1, p1, t1);
      cmp("ovs_vel", v1, 60);
      cmp("ovs_fault", longint'(fault), 1);
      cmp("ovs_code", longint'(fault_code), 2);
      step(); abort = 1'b1;
      step(); step();
      cmp("abort_fault", longint'(fault), 0);
      cmp("abort_code", longint'(fault_code), 0);
      cmp("abort_busy", longint'(busy), 0);
      cmp("abort_homed", longint'(homed), 1);

      // Homing timeout with HOME_TO=1000
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      cmp("rst2_homed", longint'(homed), 0);
      cmp("rst2_out_pos", longint'(out_pos), 0);
      cmp("rst2_out_vel", longint'(out_vel), 0);
      cfg_vmax = 20'd1000;
      start = 1'b1;
      k = 0;
      for (int i = 1; i <= 1200 && k == 0; i++) begin
         step();
         if (fault) k = i;
      end
      cmp("timeout_cycle", longint'(k), 1001);
      cmp("timeout_code", longint'(fault_code), 1);

      // Overrun with the consumer stalled across two samples
      step(); abort = 1'b1;
      step();
      pos_in = 32'd100; cfg_period = 16'd20; out_ready = 1'b0; start = 1'b1;
      step(); step();
      z_pulse = 1'b1;
      wait_sample(100, v1, p1, t1);
      cmp("ovr_first_vel", v1, 100);
      pos_in = 32'd107;
      repeat (25) step();
      cmp("ovr_flag", longint'(overrun), 1);
      cmp("ovr_vel", longint'($signed(out_vel)), 7);
      cmp("ovr_pos", longint'($signed(out_pos)), 107);
      cmp("ovr_valid", longint'(out_valid), 1);
      out_ready = 1'b1;
      step(); step();
      cmp("ovr_drained", longint'(out_valid), 0);
      cmp("ovr_sticky", longint'(overrun), 1);

      // start+abort together, then cfg_period=0
      abort = 1'b1;
      step(); step();
      cmp("abort_ovr", longint'(overrun), 0);
      start = 1'b1; abort = 1'b1;
      step(); step();
      cmp("sa_busy", longint'(busy), 0);
      cfg_period = 16'd0; pos_mode = 2; start = 1'b1;
      wait_sample(20, v1, p1, t1);
      wait_sample(20, v2, p2, t2);
      wait_sample(20, v3, p3, t3);
      cmp("p0_vel", v3, 2);
      cmp("p0_gap", t3 - t2, 2);

      // Randomized traffic
      pos_mode = 0; abort = 1'b1;
      step();
      pw = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            rst_n = 1'b0;
            repeat (3) step();
            rst_n = 1'b1;
         end
         step();
         pw = pw + int'($urandom_range(0, 20)) - 10;
         if ($urandom_range(0, 99) == 0) pw = 1048576 - int'($urandom_range(0, 20));
         if ($urandom_range(0, 99) == 0) pw = -1048576 + int'($urandom_range(0, 20));
         if (pw > 1048576) pw = pw - 1048577;
         if (pw < -1048576) pw = pw + 1048577;
         pos_in    = 32'(pw);
         out_ready = ($urandom_range(0, 9) < 7);
         start     = ($urandom_range(0, 19) == 0);
         z_pulse   = ($urandom_range(0, 29) == 0);
         abort     = ($urandom_range(0, 149) == 0) || (fault && $urandom_range(0, 9) == 0);
         if ($urandom_range(0, 59) == 0) cfg_period = 16'($urandom_range(0, 12));
         if ($urandom_range(0, 99) == 0) cfg_vmax = 20'($urandom_range(0, 200));
      end

      repeat (5) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
